// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding, counter widths and hazard helpers for pipe_ctrl
package pipe_ctrl_pkg;

    // Run/halt state encoding, kept as plain constants for legacy tools.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Counter widths.
    localparam int CYCLE_W = 32;
    localparam int EVENT_W = 16;

    // Register-number width of the MIPS-style register file.
    localparam int REG_W = 5;

    // Pipeline control bundle produced each cycle.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic pipe_en;
    } pipe_ctl_t;

    // Load-use hazard: the load in EX writes a real register that ID reads.
    function automatic logic load_use_hazard(
        input logic             mem_to_reg,
        input logic [REG_W-1:0] wreg,
        input logic             uses_rs,
        input logic [REG_W-1:0] rs,
        input logic             uses_rt,
        input logic [REG_W-1:0] rt
    );
        return mem_to_reg && (wreg != '0) &&
               ((uses_rs && (rs == wreg)) || (uses_rt && (rt == wreg)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// rtl/pipe_ctrl_sat_counter.sv - saturating event counter with asynchronous active-low reset
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard/flow controller with run/halt FSM and event counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic               ex_mem_to_reg,
    input  logic [REG_W-1:0]   ex_wreg,
    input  logic               ex_br_taken,
    input  logic               ex_jump,
    input  logic               ex_halt,
    output logic               pc_en,
    output logic               if_id_en,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic               pipe_en,
    output logic               halted,
    output logic [CYCLE_W-1:0] cycle_cnt,
    output logic [EVENT_W-1:0] jump_cnt,
    output logic [EVENT_W-1:0] branch_cnt,
    output logic [EVENT_W-1:0] stall_cnt
);

    logic [0:0] state;
    logic [0:0] state_next;
    logic       go_q;
    logic       go_rise;
    logic       run;
    logic       load_use;
    logic       redirect;
    pipe_ctl_t  ctl;

    assign go_rise  = go & ~go_q;
    assign run      = (state == ST_RUN);
    assign redirect = ex_br_taken | ex_jump;
    assign load_use = load_use_hazard(ex_mem_to_reg, ex_wreg,
                                      id_uses_rs, id_rs, id_uses_rt, id_rt);

    // Previous go level, used only for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_q <= 1'b0;
        end else begin
            go_q <= go;
        end
    end

    // Next state: halt wins over a coincident go edge; go edge resumes only from HALT.
    always_comb begin
        state_next = state;
        if (state == ST_RUN) begin
            if (ex_halt) begin
                state_next = ST_HALT;
            end
        end else begin
            if (go_rise) begin
                state_next = ST_RUN;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Control outputs by priority: HALT state, then halt > redirect > load-use > normal.
    always_comb begin
        ctl = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                id_ex_flush: 1'b0, pipe_en: 1'b1};
        if (!run) begin
            ctl.pc_en    = 1'b0;
            ctl.if_id_en = 1'b0;
            ctl.pipe_en  = 1'b0;
        end else if (ex_halt) begin
            // Freeze fetch and drain the syscall out of EX behind a bubble.
            ctl.pc_en       = 1'b0;
            ctl.if_id_en    = 1'b0;
            ctl.id_ex_flush = 1'b1;
        end else if (redirect) begin
            // Wrong-path instructions in IF and ID are squashed; the redirect target loads.
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b1;
        end else if (load_use) begin
            // Hold IF/ID one cycle so the load result is ready for forwarding.
            ctl.pc_en       = 1'b0;
            ctl.if_id_en    = 1'b0;
            ctl.id_ex_flush = 1'b1;
        end
    end

    assign pc_en       = ctl.pc_en;
    assign if_id_en    = ctl.if_id_en;
    assign if_id_flush = ctl.if_id_flush;
    assign id_ex_flush = ctl.id_ex_flush;
    assign pipe_en     = ctl.pipe_en;
    assign halted      = ~run;

    logic inc_cycle;
    logic inc_jump;
    logic inc_branch;
    logic inc_stall;

    assign inc_cycle  = run;
    assign inc_jump   = run & ex_jump;
    assign inc_branch = run & ex_br_taken;
    assign inc_stall  = run & ~ex_halt & ~redirect & load_use;

    sat_counter #(.WIDTH(CYCLE_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_cycle),
        .count (cycle_cnt)
    );

    sat_counter #(.WIDTH(EVENT_W)) u_jump_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_jump),
        .count (jump_cnt)
    );

    sat_counter #(.WIDTH(EVENT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_branch),
        .count (branch_cnt)
    );

    sat_counter #(.WIDTH(EVENT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_stall),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized self-checking bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        ex_mem_to_reg;
    logic [4:0]  ex_wreg;
    logic        ex_br_taken;
    logic        ex_jump;
    logic        ex_halt;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        pipe_en;
    logic        halted;
    logic [31:0] cycle_cnt;
    logic [15:0] jump_cnt;
    logic [15:0] branch_cnt;
    logic [15:0] stall_cnt;

    int checks;
    int errors;

    // Behavioural model state.
    bit      m_halt;
    bit      m_goq;
    longint  m_cyc;
    int      m_jmp;
    int      m_br;
    int      m_stl;

    pipe_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .go            (go),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_wreg       (ex_wreg),
        .ex_br_taken   (ex_br_taken),
        .ex_jump       (ex_jump),
        .ex_halt       (ex_halt),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .pipe_en       (pipe_en),
        .halted        (halted),
        .cycle_cnt     (cycle_cnt),
        .jump_cnt      (jump_cnt),
        .branch_cnt    (branch_cnt),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_load_use();
        bit hit_rs;
        bit hit_rt;
        hit_rs = id_uses_rs && (id_rs == ex_wreg);
        hit_rt = id_uses_rt && (id_rt == ex_wreg);
        return ex_mem_to_reg && (ex_wreg != 0) && (hit_rs || hit_rt);
    endfunction

    // Expected {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en, halted}.
    function automatic logic [5:0] model_out();
        if (m_halt)                    return 6'b000001;
        if (ex_halt)                   return 6'b000110;
        if (ex_br_taken || ex_jump)    return 6'b111110;
        if (model_load_use())          return 6'b000110;
        return 6'b110010;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        m_halt = 0; m_goq = 0; m_cyc = 0; m_jmp = 0; m_br = 0; m_stl = 0;
    endtask

    // Apply one rising edge of the reference behaviour using the current inputs.
    task automatic model_clock();
        bit rise;
        rise = go && !m_goq;
        if (!m_halt) begin
            m_cyc = (m_cyc >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cyc + 1;
            if (ex_jump)     m_jmp = sat16(m_jmp + 1);
            if (ex_br_taken) m_br  = sat16(m_br + 1);
            if (!ex_halt && !ex_br_taken && !ex_jump && model_load_use())
                m_stl = sat16(m_stl + 1);
            if (ex_halt) m_halt = 1;
        end else if (rise) begin
            m_halt = 0;
        end
        m_goq = go;
    endtask

    // Advance one clock: model follows the rising edge, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_mem_to_reg = 0; ex_wreg = 0; ex_br_taken = 0; ex_jump = 0; ex_halt = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        logic [5:0] o;
        go = 0;
        clear_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        o = {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en, halted};
        checks++;
        if (o !== 6'b110010) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", o, 6'b110010); end
        checks++;
        if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL reset_cycle_cnt got=%0d exp=0", cycle_cnt); end
        checks++;
        if ({jump_cnt, branch_cnt, stall_cnt} !== 48'd0) begin
            errors++; $display("FAIL reset_event_cnts got=%0d/%0d/%0d exp=0/0/0", jump_cnt, branch_cnt, stall_cnt);
        end
        rst_n = 1;
        tick();
        checks++;
        if (cycle_cnt !== 32'(m_cyc)) begin errors++; $display("FAIL first_cycle_cnt got=%0d exp=%0d", cycle_cnt, m_cyc); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_mem_to_reg = 1; ex_wreg = 8; id_rs = 8; id_uses_rs = 1;
        #1;
        checks++;
        if (pc_en !== 1'b0 || id_ex_flush !== 1'b1 || if_id_en !== 1'b0 || if_id_flush !== 1'b0) begin
            errors++; $display("FAIL load_use_ctl got pc_en=%b if_id_en=%b if_id_flush=%b id_ex_flush=%b exp 0/0/0/1",
                               pc_en, if_id_en, if_id_flush, id_ex_flush);
        end
        tick();
        clear_inputs();
        checks++;
        if (stall_cnt !== 16'(m_stl) || m_stl != 1) begin errors++; $display("FAIL load_use_stall_cnt got=%0d exp=1", stall_cnt); end
        #1;
        checks++;
        if (pc_en !== 1'b1) begin errors++; $display("FAIL load_use_release got pc_en=%b exp=1", pc_en); end
    endtask

    task automatic test_load_r0();
        clear_inputs();
        ex_mem_to_reg = 1; ex_wreg = 0; id_rs = 0; id_uses_rs = 1;
        #1;
        checks++;
        if (pc_en !== 1'b1 || id_ex_flush !== 1'b0) begin
            errors++; $display("FAIL load_r0_ctl got pc_en=%b id_ex_flush=%b exp 1/0", pc_en, id_ex_flush);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'(m_stl)) begin errors++; $display("FAIL load_r0_stall_cnt got=%0d exp=%0d", stall_cnt, m_stl); end
    endtask

    task automatic test_branch_over_load();
        apply_reset();
        clear_inputs();
        ex_mem_to_reg = 1; ex_wreg = 9; id_rt = 9; id_uses_rt = 1; ex_br_taken = 1;
        #1;
        checks++;
        if ({pc_en, if_id_flush, id_ex_flush} !== 3'b111) begin
            errors++; $display("FAIL branch_over_load_ctl got pc_en=%b if_id_flush=%b id_ex_flush=%b exp 1/1/1",
                               pc_en, if_id_flush, id_ex_flush);
        end
        tick();
        clear_inputs();
        checks++;
        if (branch_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL branch_over_load_cnts got branch=%0d stall=%0d exp 1/0", branch_cnt, stall_cnt);
        end
    endtask

    task automatic test_random();
        logic [5:0] o;
        logic [5:0] e;
        for (int i = 0; i < 400; i++) begin
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            id_uses_rs    = 1'($urandom);
            id_uses_rt    = 1'($urandom);
            ex_mem_to_reg = 1'($urandom);
            ex_wreg       = 5'($urandom_range(0, 3));
            ex_br_taken   = ($urandom_range(0, 5) == 0);
            ex_jump       = ($urandom_range(0, 5) == 0);
            ex_halt       = 0;
            go            = 1'($urandom);
            #1;
            o = {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en, halted};
            e = model_out();
            checks++;
            if (o !== e) begin errors++; $display("FAIL random_ctl[%0d] got=%b exp=%b", i, o, e); end
            tick();
            checks++;
            if (cycle_cnt !== 32'(m_cyc) || jump_cnt !== 16'(m_jmp) ||
                branch_cnt !== 16'(m_br) || stall_cnt !== 16'(m_stl)) begin
                errors++; $display("FAIL random_cnts[%0d] got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", i,
                                   cycle_cnt, jump_cnt, branch_cnt, stall_cnt, m_cyc, m_jmp, m_br, m_stl);
            end
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        logic [5:0] o;
        clear_inputs();
        go = 1;
        tick();
        ex_halt = 1;
        #1;
        o = {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en, halted};
        checks++;
        if (o !== 6'b000110) begin errors++; $display("FAIL halt_cycle_ctl got=%b exp=%b", o, 6'b000110); end
        tick();
        ex_halt = 0;
        checks++;
        if (halted !== 1'b1 || pipe_en !== 1'b0) begin
            errors++; $display("FAIL halt_entry got halted=%b pipe_en=%b exp 1/0", halted, pipe_en);
        end
        for (int i = 0; i < 20; i++) begin
            ex_halt       = 1'($urandom);
            ex_br_taken   = 1'($urandom);
            ex_jump       = 1'($urandom);
            ex_mem_to_reg = 1'($urandom);
            #1;
            o = {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en, halted};
            checks++;
            if (o !== 6'b000001) begin errors++; $display("FAIL halt_hold_ctl[%0d] got=%b exp=%b", i, o, 6'b000001); end
            tick();
            checks++;
            if (cycle_cnt !== 32'(m_cyc) || halted !== 1'b1) begin
                errors++; $display("FAIL halt_frozen[%0d] got cyc=%0d halted=%b exp %0d/1", i, cycle_cnt, halted, m_cyc);
            end
        end
        clear_inputs();
        go = 0;
        tick();
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_go_low got=%b exp=1", halted); end
        go = 1;
        tick();
        checks++;
        if (halted !== 1'b0 || pipe_en !== 1'b1 || m_halt) begin
            errors++; $display("FAIL halt_resume got halted=%b pipe_en=%b exp 0/1", halted, pipe_en);
        end
        // A go edge landing on the halt cycle itself must not keep the core running.
        go = 0;
        tick();
        go = 1; ex_halt = 1;
        tick();
        ex_halt = 0;
        checks++;
        if (halted !== 1'b1 || !m_halt) begin errors++; $display("FAIL go_with_halt got halted=%b exp=1", halted); end
        go = 0;
        tick();
        go = 1;
        tick();
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL resume_after_coincident got=%b exp=0", halted); end
        go = 0;
    endtask

    task automatic test_saturate();
        apply_reset();
        clear_inputs();
        ex_mem_to_reg = 1; ex_wreg = 3; id_rt = 3; id_uses_rt = 1;
        repeat (65535) tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_preload got=%0d exp=65535", stall_cnt); end
        tick();
        checks++;
        if (stall_cnt !== 16'(m_stl) || m_stl != 65535) begin
            errors++; $display("FAIL stall_saturate got=%0d exp=65535", stall_cnt);
        end
        checks++;
        if (cycle_cnt !== 32'(m_cyc)) begin errors++; $display("FAIL sat_cycle_cnt got=%0d exp=%0d", cycle_cnt, m_cyc); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_halt();
        clear_inputs();
        ex_jump = 1;
        tick();
        ex_jump = 0; ex_halt = 1;
        tick();
        ex_halt = 0;
        tick();
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL pre_reset_halted got=%b exp=1", halted); end
        @(posedge clk);
        model_clock();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (halted !== 1'b0 || pipe_en !== 1'b1 || pc_en !== 1'b1) begin
            errors++; $display("FAIL async_reset_ctl got halted=%b pipe_en=%b pc_en=%b exp 0/1/1", halted, pipe_en, pc_en);
        end
        checks++;
        if (cycle_cnt !== 32'd0 || jump_cnt !== 16'd0 || branch_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL async_reset_cnts got=%0d/%0d/%0d/%0d exp 0", cycle_cnt, jump_cnt, branch_cnt, stall_cnt);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
        checks++;
        if (cycle_cnt !== 32'(m_cyc)) begin errors++; $display("FAIL post_reset_cycle got=%0d exp=%0d", cycle_cnt, m_cyc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 0;
        go     = 0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_load_r0();
        test_branch_over_load();
        test_random();
        test_halt();
        test_saturate();
        test_reset_mid_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: go  input  1  synchronous resume request (level, from button/debouncer).
REQ-004 SHALL have port: id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 SHALL have port: id_uses_rs, id_uses_rt  input  1 each  ID instruction reads rs/rt.
REQ-006 SHALL have port: ex_mem_to_reg  input  1  instruction in EX is a load (lw/lbu).
REQ-007 SHALL have port: ex_wreg  input  5  destination register of the instruction in EX.
REQ-008 SHALL have port: ex_br_taken  input  1  beq/bne/bgez in EX resolved taken.
REQ-009 SHALL have port: ex_jump  input  1  j/jal/jr in EX.
REQ-010 SHALL have port: ex_halt  input  1  syscall in EX with halt code ($v0==10).
REQ-011 SHALL have port: pc_en, if_id_en  output  1 each  PC and IF/ID load enables.
REQ-012 SHALL have port: if_id_flush, id_ex_flush  output  1 each  insert bubble into IF/ID and ID/EX.
REQ-013 SHALL have port: pipe_en  output  1  global enable; 0 freezes all pipeline registers and suppresses RegWrite/MemWrite.
REQ-014 SHALL have port: halted  output  1  FSM in HALT.
REQ-015 SHALL have port: cycle_cnt  output  32  run-cycle count.
REQ-016 SHALL have port: jump_cnt, branch_cnt, stall_cnt  output  16 each  event counts.

Function
REQ-017 SHALL implement FSM states RUN and HALT; RUN->HALT on ex_halt in RUN; HALT->RUN on go rising edge.
REQ-018 SHALL detect the go rising edge as go & ~go_q, with go_q registered every cycle; go edge in RUN is ignored.
REQ-019 SHALL compute load_use = ex_mem_to_reg & (ex_wreg!=0) & ((id_uses_rs & id_rs==ex_wreg) | (id_uses_rt & id_rt==ex_wreg)).
REQ-020 SHALL set redirect = ex_br_taken | ex_jump.
REQ-021 SHALL drive, in RUN, priority ex_halt > redirect > load_use > normal; outputs are combinational from state and inputs (0-cycle latency).
REQ-022 SHALL, on ex_halt in RUN: pc_en=0, if_id_en=0, id_ex_flush=1, if_id_flush=0, pipe_en=1.
REQ-023 SHALL, on redirect: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1.
REQ-024 SHALL, on load_use without redirect: pc_en=0, if_id_en=0, id_ex_flush=1, if_id_flush=0 (one-cycle bubble).
REQ-025 SHALL, in normal RUN: pc_en=1, if_id_en=1, both flushes 0, pipe_en=1.
REQ-026 SHALL, in HALT: pipe_en=0, pc_en=0, if_id_en=0, both flushes 0, halted=1, regardless of inputs.
REQ-027 SHALL increment cycle_cnt every RUN cycle, including the ex_halt cycle; not in HALT.
REQ-028 SHALL increment jump_cnt on ex_jump, branch_cnt on ex_br_taken, stall_cnt on load_use only when it wins priority; RUN only.
REQ-029 SHALL saturate every counter at its all-ones value (no wrap).
REQ-030 SHALL treat a go edge coincident with ex_halt in RUN as ignored (state becomes HALT).

Reset
REQ-031 SHALL, while rst_n=0, force state=RUN, go_q=0, all counters=0, halted=0; combinational outputs then follow RUN rules.
REQ-032 SHALL abort HALT immediately on reset assertion mid-halt.

Structure
REQ-033 SHALL place state encoding (RUN=0, HALT=1) and counter widths (32, 16) in shared package pipe_ctrl_pkg.
REQ-034 SHALL use one sub-module sat_counter (parameter WIDTH; inputs clk, rst_n, inc; output count), instantiated four times.

Verification
REQ-035 SHALL cover: ex_mem_to_reg=1, ex_wreg=8, id_rs=8, id_uses_rs=1 -> one cycle pc_en=0, id_ex_flush=1; stall_cnt 0->1.
REQ-036 SHALL cover: same load with ex_wreg=0 -> no stall, stall_cnt stays 0.
REQ-037 SHALL cover: ex_br_taken=1 with simultaneous load_use -> if_id_flush=1, id_ex_flush=1, pc_en=1; branch_cnt=1, stall_cnt=0.
REQ-038 SHALL cover: ex_halt=1 for one cycle -> next cycle halted=1, pipe_en=0; cycle_cnt frozen for 20 cycles; go held high from before halt -> no resume until go falls and rises.
REQ-039 SHALL cover: stall_cnt preloaded by 65535 stalls, one more stall -> stall_cnt stays 65535.
REQ-040 SHALL cover: rst_n low mid-HALT -> halted=0, all counters 0 asynchronously, before next clk edge.
